// File: rtl/scan_addr_gen.sv
// Debug-display address source: switch pass-through or a stepped/timed scan counter.
// Optional macro SCAN_AUTO_EN builds the auto-scan timer for mode 11.
module scan_addr_gen #(
   parameter int ADDR_W   = 5,
   parameter int ADDR_MIN = 0,
   parameter int ADDR_MAX = 31,
   parameter int AUTO_DIV = 50000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              dir,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] address,
   output logic [ADDR_W-1:0] input_a,
   output logic              scan_active,
   output logic              wrap
);

   localparam logic [ADDR_W-1:0] LP_MIN = ADDR_W'(ADDR_MIN);
   localparam logic [ADDR_W-1:0] LP_MAX = ADDR_W'(ADDR_MAX);

   logic              r_s1, r_s2, r_s3;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;
   logic              w_wrap_nxt;
   logic              w_step_rise;
   logic              w_addr_zero;
   logic              w_legacy;
   logic              w_scan_sel;
   logic              w_load;
   logic              w_adv;
   logic              w_below;
   logic              w_above;

   assign w_step_rise = r_s2 & ~r_s3;
   assign w_addr_zero = (address == '0);
   assign w_legacy    = (mode == 2'b01);
   assign w_scan_sel  = mode[1] | (w_legacy & w_addr_zero);
   assign w_load      = w_legacy & ~w_addr_zero;

   // Range checks only exist where the bound can actually be violated.
   generate
      if (ADDR_MIN > 0) begin : g_below
         assign w_below = (r_cnt < LP_MIN);
      end else begin : g_no_below
         assign w_below = 1'b0;
      end
      if (ADDR_MAX < (2**ADDR_W) - 1) begin : g_above
         assign w_above = (r_cnt > LP_MAX);
      end else begin : g_no_above
         assign w_above = 1'b0;
      end
   endgenerate

`ifdef SCAN_AUTO_EN
   localparam int TMR_W = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;
   localparam logic [TMR_W-1:0] LP_TMR_LAST = TMR_W'(AUTO_DIV - 1);

   logic [TMR_W-1:0] r_tmr;
   logic             w_timed;
   logic             w_tick;

   assign w_timed = (mode == 2'b11);
   assign w_tick  = w_timed & (r_tmr == LP_TMR_LAST);
   assign w_adv   = w_timed ? w_tick : (w_scan_sel & w_step_rise);

   // Any cycle outside mode 11 parks the timer, so re-entry restarts the full period.
   always_ff @(posedge clk) begin
      if (rst || !w_timed) r_tmr <= '0;
      else if (w_tick)     r_tmr <= '0;
      else                 r_tmr <= r_tmr + TMR_W'(1);
   end
`else
   logic w_unused_div;
   assign w_unused_div = |AUTO_DIV;
   assign w_adv        = w_scan_sel & w_step_rise;
`endif

   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_wrap_nxt = 1'b0;
      if (w_below || w_above) begin
         w_cnt_nxt  = LP_MIN;
         w_wrap_nxt = 1'b1;
      end else if (!dir) begin
         if (r_cnt == LP_MAX) begin
            w_cnt_nxt  = LP_MIN;
            w_wrap_nxt = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + ADDR_W'(1);
         end
      end else begin
         if (r_cnt == LP_MIN) begin
            w_cnt_nxt  = LP_MAX;
            w_wrap_nxt = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt - ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1        <= 1'b0;
         r_s2        <= 1'b0;
         r_s3        <= 1'b0;
         r_cnt       <= LP_MIN;
         input_a     <= '0;
         scan_active <= 1'b0;
         wrap        <= 1'b0;
      end else begin
         r_s1 <= step;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         wrap <= 1'b0;
         // Legacy load beats a coincident step edge.
         if (w_load) begin
            r_cnt <= LP_MIN;
         end else if (w_adv) begin
            r_cnt <= w_cnt_nxt;
            wrap  <= w_wrap_nxt;
         end
         input_a     <= w_scan_sel ? r_cnt : address;
         scan_active <= w_scan_sel;
      end
   end

endmodule

// File: tb/tb_scan_addr_gen.sv
// Directed bench for scan_addr_gen: full-range instance plus a narrow 4..6 range instance.
module tb_scan_addr_gen;

   logic       clk = 1'b0;
   logic       rst, step, dir;
   logic [1:0] mode;
   logic [4:0] address;
   logic [4:0] a0, a1;
   logic       sa0, sa1, w0, w1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   scan_addr_gen #(.ADDR_W(5), .ADDR_MIN(0), .ADDR_MAX(31), .AUTO_DIV(4)) dut0 (
      .clk(clk), .rst(rst), .step(step), .dir(dir), .mode(mode), .address(address),
      .input_a(a0), .scan_active(sa0), .wrap(w0));

   scan_addr_gen #(.ADDR_W(5), .ADDR_MIN(4), .ADDR_MAX(6), .AUTO_DIV(4)) dut1 (
      .clk(clk), .rst(rst), .step(step), .dir(dir), .mode(mode), .address(address),
      .input_a(a1), .scan_active(sa1), .wrap(w1));

   typedef struct {
      logic [1:0] mode;
      logic [4:0] addr;
      logic       dir;
      logic       step;
      logic [4:0] ea;
      logic       esa;
      logic       ew;
   } vec_t;

   vec_t tbl[32];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) cyc();
      rst = 1'b0;
   endtask

   // One 5-high/5-low step pulse on dut1; new value expected on input_a after the 4th edge.
   task automatic pulse1(input string name, input int exp_a, input int exp_w);
      step = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k == 5) step = 1'b0;
         cyc();
         if (k == 2) chk({name, " wrap@update"}, w1, exp_w);
         if (k == 3) begin
            chk({name, " input_a"}, a1, exp_a);
            chk({name, " wrap after"}, w1, 0);
         end
         if (k == 9) chk({name, " single advance"}, a1, exp_a);
      end
   endtask

   initial begin
      rst = 1'b0; step = 1'b0; dir = 1'b0; mode = 2'b00; address = 5'd0;

      // Table: legacy scan with three step pulses, then pass-through and the reload.
      for (int i = 0; i < 30; i++) begin
         tbl[i].mode = 2'b01; tbl[i].addr = 5'd0; tbl[i].dir = 1'b0;
         tbl[i].step = ((i % 10) < 5);
         tbl[i].ea   = (i < 3) ? 5'd0 : (i < 13) ? 5'd1 : (i < 23) ? 5'd2 : 5'd3;
         tbl[i].esa  = 1'b1; tbl[i].ew = 1'b0;
      end
      tbl[30] = '{mode: 2'b01, addr: 5'd9, dir: 1'b0, step: 1'b0, ea: 5'd9, esa: 1'b0, ew: 1'b0};
      tbl[31] = '{mode: 2'b01, addr: 5'd0, dir: 1'b0, step: 1'b0, ea: 5'd0, esa: 1'b1, ew: 1'b0};

      // Reset overrides an active step and a nonzero address.
      rst = 1'b1; step = 1'b1; mode = 2'b01; address = 5'd7;
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk("reset input_a", a0, 0);
         chk("reset scan_active", sa0, 0);
         chk("reset wrap", w0, 0);
      end
      rst = 1'b0; step = 1'b0; address = 5'd0;

      for (int i = 0; i < 32; i++) begin
         mode = tbl[i].mode; address = tbl[i].addr; dir = tbl[i].dir; step = tbl[i].step;
         cyc();
         chk($sformatf("tbl[%0d] input_a", i), a0, tbl[i].ea);
         chk($sformatf("tbl[%0d] scan_active", i), sa0, tbl[i].esa);
         chk($sformatf("tbl[%0d] wrap", i), w0, tbl[i].ew);
      end

      // Narrow range wrap up then down on dut1.
      do_reset(1);
      mode = 2'b10; dir = 1'b0; address = 5'd0; step = 1'b0;
      cyc();
      chk("narrow start", a1, 4);
      chk("narrow scan_active", sa1, 1);
      pulse1("up 4->5", 5, 0);
      pulse1("up 5->6", 6, 0);
      pulse1("up 6->4", 4, 1);
      dir = 1'b1;
      pulse1("down 4->6", 6, 1);

      // Collision: legacy address goes nonzero while step_rise is high.
      do_reset(1);
      mode = 2'b01; dir = 1'b0; address = 5'd0;
      step = 1'b1; repeat (5) cyc(); step = 1'b0; repeat (5) cyc();
      chk("collision pre cnt", a0, 1);
      step = 1'b1;
      cyc(); cyc();
      address = 5'd3;
      cyc();
      chk("collision input_a", a0, 3);
      chk("collision wrap", w0, 0);
      chk("collision scan_active", sa0, 0);
      address = 5'd0; step = 1'b0;
      cyc();
      chk("collision cnt reloaded", a0, 0);
      chk("collision wrap next", w0, 0);

      // Mid-scan reset returns the counter to its reset value.
      step = 1'b1; repeat (5) cyc(); step = 1'b0; repeat (5) cyc();
      chk("pre-reset cnt", a0, 1);
      rst = 1'b1;
      cyc();
      chk("mid reset input_a", a0, 0);
      chk("mid reset scan_active", sa0, 0);
      rst = 1'b0;
      cyc();
      chk("post reset cnt", a0, 0);

`ifdef SCAN_AUTO_EN
      // Timed scan: steps are ignored, 4 cycles per advance, restart on re-entry.
      do_reset(1);
      mode = 2'b11; dir = 1'b0; address = 5'd0;
      for (int k = 0; k < 10; k++) begin
         step = (k < 2);
         cyc();
         if (k == 3) chk("timed before tick", a0, 0);
         if (k == 4) chk("timed first", a0, 1);
         if (k == 7) chk("timed hold", a0, 1);
         if (k == 8) chk("timed second", a0, 2);
      end
      mode = 2'b10;
      repeat (3) cyc();
      chk("timed paused", a0, 2);
      mode = 2'b11;
      for (int k = 0; k < 5; k++) begin
         cyc();
         if (k == 3) chk("reentry before tick", a0, 2);
         if (k == 4) chk("reentry tick", a0, 3);
      end
`else
      // Without the timer, mode 11 is step-driven.
      begin
         int changed = 0;
         do_reset(1);
         mode = 2'b11; dir = 1'b0; address = 5'd0; step = 1'b0;
         for (int k = 0; k < 100; k++) begin
            cyc();
            if (a0 != 5'd0) changed++;
         end
         chk("mode11 no-timer changes", changed, 0);
         chk("mode11 scan_active", sa0, 1);
         step = 1'b1; repeat (5) cyc(); step = 1'b0; repeat (5) cyc();
         chk("mode11 step advance", a0, 1);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
